tnn_neuron_sequencer: RTL and testbench
=======================================

# tnn_neuron_sequencer

Time-multiplexes one shared 3-bit approximate comparison unit across N operand pairs of a TNN neuron. The sequencer captures the pair vectors, steps through them one per cycle, counts asserted comparator outputs as votes, and compares the vote count against a threshold to produce the neuron's binary output. It sits between the layer buffer and a single instance of a library comparator circuit (3-bit a/b in, 1-bit out), so any evolved variant can be swapped in without changing the sequencing.

## Interface
- N_PAIRS, 8, number of operand pairs per neuron evaluation (legal 1..64)
- OP_W, 3, operand width of the shared unit
- CNT_W, $clog2(N_PAIRS+1), vote counter width (derived, not overridden)

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request evaluation; accepted only when ready=1
- ready  out  1  high in IDLE and DONE
- a_vec  in  N_PAIRS*OP_W  operand A pairs, pair i at [i*OP_W +: OP_W]; sampled on accepted start
- b_vec  in  N_PAIRS*OP_W  operand B pairs, same packing
- threshold  in  CNT_W  vote threshold; sampled on accepted start
- unit_a  out  OP_W  operand A to shared unit
- unit_b  out  OP_W  operand B to shared unit
- unit_out  in  1  shared unit result (combinational from unit_a/unit_b)
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse on result update
- result  out  1  1 when votes >= threshold; held until the next done
- votes  out  CNT_W  final vote count; held with result

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE.
- IDLE: ready=1, busy=0. start=1 → latch a_vec, b_vec, threshold; clear idx and the accumulator; go to RUN.
- RUN: unit_a/unit_b are driven from registered copies of the latched pair idx. Each cycle the accumulator += unit_out (0/1, no saturation needed since max = N_PAIRS fits CNT_W). idx increments; at idx = N_PAIRS-1, the final count is computed (accumulator + unit_out), votes and result are registered, and the FSM goes to DONE.
- DONE: done=1 for exactly this cycle, ready=1. start=1 here is accepted identically to IDLE (back-to-back), going to RUN; otherwise go to IDLE.
- start while busy=1: ignored, with no effect on the latched operands or the count.
- Input vectors may change freely after acceptance; only latched copies are used.
- Comparison is unsigned: result = (votes >= threshold). threshold=0 always gives result=1, and threshold > N_PAIRS always gives result=0.
- unit_a/unit_b in IDLE/DONE: hold the last driven pair (pair 0 after reset, value 0).

## Timing
- Reset values: ready=1, busy=0, done=0, result=0, votes=0, unit_a=0, unit_b=0, internal idx=0, accumulator=0.
- Assertion of rst_n=0 at any time, including mid-RUN, clears everything asynchronously and aborts the evaluation. No done is issued for the aborted evaluation.
- start accepted at edge k. busy=1 in cycles k+1 .. k+N_PAIRS, and pair i is presented in cycle k+1+i. done=1 in cycle k+N_PAIRS+1, with result/votes valid from that cycle onward.
- Latency is start → done = N_PAIRS+1 cycles. Back-to-back throughput is one evaluation per N_PAIRS+1 cycles.
- unit_out is sampled at the end of the same cycle in which its pair is presented. This is a single combinational path unit_a/b → unit → accumulator, with no pipelining.
- N_PAIRS=1: RUN lasts one cycle, and done appears 2 cycles after start.

## Test plan
Bench model: unit_out = (unit_a > unit_b), unsigned. N_PAIRS=8.
- Reset behaviour: hold rst_n=0, then release → ready=1, busy=0, done=0, result=0, votes=0, unit_a=unit_b=0.
- Basic evaluation: a_vec pairs = 7,7,7,7,0,0,0,0; b_vec all 3; threshold=4 → unit_a sequence 7,7,7,7,0,0,0,0 on cycles k+1..k+8; done at k+9; votes=4, result=1. Rerun with threshold=5 → votes=4, result=0.
- Thresholds at the boundaries: all pairs a=5, b=2 with threshold=8 → votes=8, result=1. All a=b=6 with threshold=0 → votes=0, result=1.
- Protocol: pulse start at k+3 mid-RUN with different vectors → ignored, and the first result is unchanged. Change a_vec at k+2 → no effect. start held high in the DONE cycle → new RUN begins next cycle, with the second done exactly 9 cycles after the first.
- Abort: drop rst_n at k+5 → all outputs return to reset values immediately and no done is seen. After release, a fresh start completes normally with correct votes.
- Randomised: 200 random vector/threshold sets checked against a reference popcount, with done spacing and busy width checked on every run.

Source files
------------

// File: rtl/tnn_neuron_sequencer.sv
// Time-multiplexes one shared OP_W-bit comparison unit across N_PAIRS operand pairs,
// counts the unit's votes and thresholds the count into a single neuron output.
module tnn_neuron_sequencer #(
  parameter  int N_PAIRS = 8,
  parameter  int OP_W    = 3,
  localparam int CNT_W   = $clog2(N_PAIRS + 1)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      start_i,
  output logic                      ready_o,
  input  logic [N_PAIRS*OP_W-1:0]   a_vec_i,
  input  logic [N_PAIRS*OP_W-1:0]   b_vec_i,
  input  logic [CNT_W-1:0]          threshold_i,
  output logic [OP_W-1:0]           unit_a_o,
  output logic [OP_W-1:0]           unit_b_o,
  input  logic                      unit_out_i,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      result_o,
  output logic [CNT_W-1:0]          votes_o
);

  localparam int IDX_W = (N_PAIRS > 1) ? $clog2(N_PAIRS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e                    state_q;
  logic [N_PAIRS*OP_W-1:0]   a_q;
  logic [N_PAIRS*OP_W-1:0]   b_q;
  logic [CNT_W-1:0]          thr_q;
  logic [IDX_W-1:0]          idx_q;
  logic [CNT_W-1:0]          acc_q;
  logic [OP_W-1:0]           unit_a_q;
  logic [OP_W-1:0]           unit_b_q;
  logic                      done_q;
  logic                      result_q;
  logic [CNT_W-1:0]          votes_q;

  logic [CNT_W-1:0]          acc_d;
  logic [IDX_W-1:0]          idx_d;
  logic                      last_pair;

  // The unit result for the pair on the bus this cycle is folded in at the closing edge.
  assign acc_d     = acc_q + CNT_W'(unit_out_i);
  assign idx_d     = idx_q + IDX_W'(1);
  assign last_pair = (idx_q == IDX_W'(N_PAIRS - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      thr_q    <= '0;
      idx_q    <= '0;
      acc_q    <= '0;
      unit_a_q <= '0;
      unit_b_q <= '0;
      done_q   <= 1'b0;
      result_q <= 1'b0;
      votes_q  <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          done_q <= 1'b0;
          if (start_i) begin
            a_q      <= a_vec_i;
            b_q      <= b_vec_i;
            thr_q    <= threshold_i;
            idx_q    <= '0;
            acc_q    <= '0;
            // Pair 0 comes straight from the inputs so it is on the bus in the first RUN cycle.
            unit_a_q <= a_vec_i[OP_W-1:0];
            unit_b_q <= b_vec_i[OP_W-1:0];
            state_q  <= RUN;
          end else begin
            state_q  <= IDLE;
          end
        end
        RUN: begin
          if (last_pair) begin
            votes_q  <= acc_d;
            result_q <= (acc_d >= thr_q);
            done_q   <= 1'b1;
            state_q  <= DONE;
          end else begin
            acc_q    <= acc_d;
            idx_q    <= idx_d;
            unit_a_q <= a_q[idx_d*OP_W +: OP_W];
            unit_b_q <= b_q[idx_d*OP_W +: OP_W];
            state_q  <= RUN;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ready_o  = (state_q != RUN);
  assign busy_o   = (state_q == RUN);
  assign done_o   = done_q;
  assign result_o = result_q;
  assign votes_o  = votes_q;
  assign unit_a_o = unit_a_q;
  assign unit_b_o = unit_b_q;

endmodule

// File: tb/tb_tnn_neuron_sequencer.sv
// Directed and random checks of tnn_neuron_sequencer with a "greater-than" comparator
// standing in for the shared unit.
module tb_tnn_neuron_sequencer;

  localparam int N     = 8;
  localparam int OPW   = 3;
  localparam int CNTW  = 4;
  localparam int VW    = N * OPW;

  logic            clk;
  logic            rst_n;
  logic            start;
  logic            ready;
  logic [VW-1:0]   a_vec;
  logic [VW-1:0]   b_vec;
  logic [CNTW-1:0] threshold;
  logic [OPW-1:0]  unit_a;
  logic [OPW-1:0]  unit_b;
  logic            unit_out;
  logic            busy;
  logic            done;
  logic            result;
  logic [CNTW-1:0] votes;

  int total = 0;
  int bad   = 0;

  tnn_neuron_sequencer #(.N_PAIRS(N), .OP_W(OPW)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .start_i     (start),
    .ready_o     (ready),
    .a_vec_i     (a_vec),
    .b_vec_i     (b_vec),
    .threshold_i (threshold),
    .unit_a_o    (unit_a),
    .unit_b_o    (unit_b),
    .unit_out_i  (unit_out),
    .busy_o      (busy),
    .done_o      (done),
    .result_o    (result),
    .votes_o     (votes)
  );

  assign unit_out = (unit_a > unit_b);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int refVotes(input logic [VW-1:0] a, input logic [VW-1:0] b);
    int n = 0;
    for (int i = 0; i < N; i++)
      if (a[i*OPW +: OPW] > b[i*OPW +: OPW]) n++;
    return n;
  endfunction

  task automatic checkResetValues(input string tag);
    checkOutput({tag, " ready"},  32'(ready),  1);
    checkOutput({tag, " busy"},   32'(busy),   0);
    checkOutput({tag, " done"},   32'(done),   0);
    checkOutput({tag, " result"}, 32'(result), 0);
    checkOutput({tag, " votes"},  32'(votes),  0);
    checkOutput({tag, " unit_a"}, 32'(unit_a), 0);
    checkOutput({tag, " unit_b"}, 32'(unit_b), 0);
  endtask

  // Drive a start for one edge; returns in the first RUN cycle (k+1).
  task automatic applyStimulus(input logic [VW-1:0] a, input logic [VW-1:0] b,
                               input logic [CNTW-1:0] thr);
    a_vec     = a;
    b_vec     = b;
    threshold = thr;
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  // Called in cycle k+1: walks pairs 0..N-1, then checks the done cycle k+N+1.
  task automatic runFromAccepted(input string tag, input logic [VW-1:0] a, input logic [VW-1:0] b,
                                 input int expVotes, input int expRes);
    for (int i = 0; i < N; i++) begin
      checkOutput({tag, " busy"},   32'(busy),   1);
      checkOutput({tag, " done"},   32'(done),   0);
      checkOutput({tag, " unit_a"}, 32'(unit_a), 32'(a[i*OPW +: OPW]));
      checkOutput({tag, " unit_b"}, 32'(unit_b), 32'(b[i*OPW +: OPW]));
      tick();
    end
    checkOutput({tag, " done"},   32'(done),   1);
    checkOutput({tag, " ready"},  32'(ready),  1);
    checkOutput({tag, " busy"},   32'(busy),   0);
    checkOutput({tag, " votes"},  32'(votes),  32'(expVotes));
    checkOutput({tag, " result"}, 32'(result), 32'(expRes));
  endtask

  task automatic runEval(input string tag, input logic [VW-1:0] a, input logic [VW-1:0] b,
                         input logic [CNTW-1:0] thr, input int expVotes, input int expRes);
    applyStimulus(a, b, thr);
    runFromAccepted(tag, a, b, expVotes, expRes);
  endtask

  logic [VW-1:0]   basicA;
  logic [VW-1:0]   rndA;
  logic [VW-1:0]   rndB;
  logic [CNTW-1:0] rndT;
  int              rndV;

  initial begin
    basicA    = {3'd0, 3'd0, 3'd0, 3'd0, 3'd7, 3'd7, 3'd7, 3'd7};
    rst_n     = 1'b0;
    start     = 1'b0;
    a_vec     = '0;
    b_vec     = '0;
    threshold = '0;

    $display("[TB] reset");
    tick();
    tick();
    checkResetValues("in_reset");
    #2 rst_n = 1'b1;
    tick();
    checkResetValues("after_reset");

    $display("[TB] basic evaluation");
    runEval("basic_t4", basicA, {8{3'd3}}, 4'd4, 4, 1);
    tick();
    checkOutput("done_one_cycle", 32'(done), 0);
    checkOutput("result_held", 32'(result), 1);
    runEval("basic_t5", basicA, {8{3'd3}}, 4'd5, 4, 0);

    $display("[TB] threshold boundaries");
    runEval("all_win_t8", {8{3'd5}}, {8{3'd2}}, 4'd8, 8, 1);
    runEval("none_t0",    {8{3'd6}}, {8{3'd6}}, 4'd0, 0, 1);
    runEval("all_win_t9", {8{3'd5}}, {8{3'd2}}, 4'd9, 8, 0);

    $display("[TB] protocol: input changes and start while busy");
    applyStimulus(basicA, {8{3'd3}}, 4'd4);
    tick();
    a_vec = '0;
    checkOutput("chg_k2 unit_a", 32'(unit_a), 7);
    tick();
    a_vec     = {8{3'd7}};
    b_vec     = '0;
    threshold = 4'd15;
    start     = 1'b1;
    checkOutput("chg_k3 unit_a", 32'(unit_a), 7);
    tick();
    start = 1'b0;
    checkOutput("chg_k4 unit_a", 32'(unit_a), 7);
    checkOutput("chg_k4 unit_b", 32'(unit_b), 3);
    for (int i = 4; i < N; i++) begin
      tick();
      checkOutput("chg_late unit_a", 32'(unit_a), 32'(basicA[i*OPW +: OPW]));
      checkOutput("chg_late done",   32'(done), 0);
    end
    tick();
    checkOutput("ignored done",   32'(done), 1);
    checkOutput("ignored votes",  32'(votes), 4);
    checkOutput("ignored result", 32'(result), 1);

    $display("[TB] back-to-back start in DONE");
    a_vec     = {8{3'd5}};
    b_vec     = {8{3'd2}};
    threshold = 4'd8;
    start     = 1'b1;
    tick();
    start = 1'b0;
    runFromAccepted("b2b", {8{3'd5}}, {8{3'd2}}, 8, 1);

    $display("[TB] abort mid-run");
    tick();
    applyStimulus(basicA, {8{3'd3}}, 4'd0);
    for (int i = 0; i < 4; i++) tick();
    checkOutput("pre_abort busy", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    checkResetValues("abort");
    for (int i = 0; i < 10; i++) begin
      tick();
      checkOutput("abort no_done", 32'(done), 0);
    end
    rst_n = 1'b1;
    tick();
    checkResetValues("abort_release");
    for (int i = 0; i < 6; i++) begin
      tick();
      checkOutput("abort idle done", 32'(done), 0);
    end
    runEval("post_abort", basicA, {8{3'd3}}, 4'd4, 4, 1);

    $display("[TB] random evaluations");
    for (int r = 0; r < 200; r++) begin
      rndA = VW'($urandom);
      rndB = VW'($urandom);
      rndT = CNTW'($urandom_range(0, 15));
      rndV = refVotes(rndA, rndB);
      runEval("random", rndA, rndB, rndT, rndV, (rndV >= int'(rndT)) ? 1 : 0);
      if ($urandom_range(0, 1) == 1) tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
